// File: rtl/wallace_mult_stream_if.sv
// Word-stream wrapper around an external combinational multiplier.
// Gathers two operands, holds them through a settle window, then streams the product.
module wallace_mult_stream_if #(
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned OP_W          = 128,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic [OP_W-1:0]     mult_a,
  output logic [OP_W-1:0]     mult_b,
  input  logic [2*OP_W-1:0]   mult_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned NW    = OP_W / WORD_W;
  localparam int unsigned NR    = 2 * NW;
  localparam int unsigned RES_W = 2 * OP_W;
  localparam int unsigned CNT_W = $clog2(NR);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_SETTLE = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [OP_W-1:0]     mult_a_q, mult_a_d;
  logic [OP_W-1:0]     mult_b_q, mult_b_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;

  logic                in_acc_c;
  logic                out_acc_c;
  logic [CNT_W-1:0]    cnt_nxt_c;

  assign in_acc_c  = in_valid && in_ready_q;
  assign out_acc_c = out_valid_q && out_ready;
  assign cnt_nxt_c = cnt_q + CNT_W'(1);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    set_d      = set_q;
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    result_d   = result_q;
    out_data_d = out_data_q;

    case (state_q)
      S_LOAD_A: begin
        if (in_acc_c) begin
          for (int k = 0; k < int'(NW); k++) begin
            if (cnt_q == CNT_W'(k)) mult_a_d[k*WORD_W +: WORD_W] = in_data;
          end
          if (cnt_q == CNT_W'(NW - 1)) begin
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_nxt_c;
          end
        end
      end

      S_LOAD_B: begin
        if (in_acc_c) begin
          for (int k = 0; k < int'(NW); k++) begin
            if (cnt_q == CNT_W'(k)) mult_b_d[k*WORD_W +: WORD_W] = in_data;
          end
          if (cnt_q == CNT_W'(NW - 1)) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
            set_d   = '0;
          end else begin
            cnt_d = cnt_nxt_c;
          end
        end
      end

      S_SETTLE: begin
        // Multicycle path: the product is only sampled on the final settle edge
        if (set_q == SET_W'(SETTLE_CYCLES)) begin
          state_d    = S_DRAIN;
          result_d   = mult_result;
          out_data_d = mult_result[WORD_W-1:0];
          cnt_d      = '0;
          set_d      = '0;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end

      S_DRAIN: begin
        if (out_acc_c) begin
          if (cnt_q == CNT_W'(NR - 1)) begin
            state_d = S_LOAD_A;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_nxt_c;
            for (int k = 0; k < int'(NR); k++) begin
              if (cnt_nxt_c == CNT_W'(k)) out_data_d = result_q[k*WORD_W +: WORD_W];
            end
          end
        end
      end

      default: begin
        state_d = S_LOAD_A;
        cnt_d   = '0;
        set_d   = '0;
      end
    endcase

    in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    out_valid_d = (state_d == S_DRAIN);
    out_last_d  = (state_d == S_DRAIN) && (cnt_d == CNT_W'(NR - 1));
    busy_d      = !((state_d == S_LOAD_A) && (cnt_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_A;
      cnt_q       <= '0;
      set_q       <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      result_q    <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      set_q       <= set_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      result_q    <= result_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule
